// File: rtl/tc_checker_pkg.sv
// Shared constants for the stream checker.
// Contents: pattern mode codes, checker FSM state encoding and the
// maximal-length LFSR tap table (bit p-1 set for polynomial term x^p).
package tc_checker_pkg;

  localparam logic [1:0] TC_MODE_INCR  = 2'd0;
  localparam logic [1:0] TC_MODE_LFSR  = 2'd1;
  localparam logic [1:0] TC_MODE_WALK  = 2'd2;
  localparam logic [1:0] TC_MODE_CONST = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  // Single tap bit for polynomial term x^p.
  function automatic logic [63:0] tp(input int unsigned p);
    return 64'(1) << (p - 32'd1);
  endfunction

  // Tap mask for a maximal-length Fibonacci LFSR of the given width (2..64).
  function automatic logic [63:0] lfsr_taps(input int unsigned width);
    logic [63:0] t;
    t = '0;
    case (width)
      2:  t = tp(2)  | tp(1);
      3:  t = tp(3)  | tp(2);
      4:  t = tp(4)  | tp(3);
      5:  t = tp(5)  | tp(3);
      6:  t = tp(6)  | tp(5);
      7:  t = tp(7)  | tp(6);
      8:  t = tp(8)  | tp(6)  | tp(5)  | tp(4);
      9:  t = tp(9)  | tp(5);
      10: t = tp(10) | tp(7);
      11: t = tp(11) | tp(9);
      12: t = tp(12) | tp(6)  | tp(4)  | tp(1);
      13: t = tp(13) | tp(4)  | tp(3)  | tp(1);
      14: t = tp(14) | tp(5)  | tp(3)  | tp(1);
      15: t = tp(15) | tp(14);
      16: t = tp(16) | tp(15) | tp(13) | tp(4);
      17: t = tp(17) | tp(14);
      18: t = tp(18) | tp(11);
      19: t = tp(19) | tp(6)  | tp(2)  | tp(1);
      20: t = tp(20) | tp(17);
      21: t = tp(21) | tp(19);
      22: t = tp(22) | tp(21);
      23: t = tp(23) | tp(18);
      24: t = tp(24) | tp(23) | tp(22) | tp(17);
      25: t = tp(25) | tp(22);
      26: t = tp(26) | tp(6)  | tp(2)  | tp(1);
      27: t = tp(27) | tp(5)  | tp(2)  | tp(1);
      28: t = tp(28) | tp(25);
      29: t = tp(29) | tp(27);
      30: t = tp(30) | tp(6)  | tp(4)  | tp(1);
      31: t = tp(31) | tp(28);
      32: t = tp(32) | tp(22) | tp(2)  | tp(1);
      33: t = tp(33) | tp(20);
      34: t = tp(34) | tp(27) | tp(2)  | tp(1);
      35: t = tp(35) | tp(33);
      36: t = tp(36) | tp(25);
      37: t = tp(37) | tp(5)  | tp(4)  | tp(3) | tp(2) | tp(1);
      38: t = tp(38) | tp(6)  | tp(5)  | tp(1);
      39: t = tp(39) | tp(35);
      40: t = tp(40) | tp(38) | tp(21) | tp(19);
      41: t = tp(41) | tp(38);
      42: t = tp(42) | tp(41) | tp(20) | tp(19);
      43: t = tp(43) | tp(42) | tp(38) | tp(37);
      44: t = tp(44) | tp(43) | tp(18) | tp(17);
      45: t = tp(45) | tp(44) | tp(42) | tp(41);
      46: t = tp(46) | tp(45) | tp(26) | tp(25);
      47: t = tp(47) | tp(42);
      48: t = tp(48) | tp(47) | tp(21) | tp(20);
      49: t = tp(49) | tp(40);
      50: t = tp(50) | tp(49) | tp(24) | tp(23);
      51: t = tp(51) | tp(50) | tp(36) | tp(35);
      52: t = tp(52) | tp(49);
      53: t = tp(53) | tp(52) | tp(38) | tp(37);
      54: t = tp(54) | tp(53) | tp(18) | tp(17);
      55: t = tp(55) | tp(31);
      56: t = tp(56) | tp(55) | tp(35) | tp(34);
      57: t = tp(57) | tp(50);
      58: t = tp(58) | tp(39);
      59: t = tp(59) | tp(58) | tp(38) | tp(37);
      60: t = tp(60) | tp(59);
      61: t = tp(61) | tp(60) | tp(46) | tp(45);
      62: t = tp(62) | tp(61) | tp(6)  | tp(5);
      63: t = tp(63) | tp(62);
      64: t = tp(64) | tp(63) | tp(61) | tp(60);
      default: t = '0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tc_pattern_gen.sv
// Pattern generator: produces beat k of the selected pattern; load restarts
// at beat 0, advance steps to the next beat.
// Ports: clk, rst (sync, active-high), load, advance, mode[1:0], data[DATA_W-1:0].
module tc_pattern_gen
  import tc_checker_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter logic [63:0] SEED   = 64'd1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] data
);

  localparam logic [63:0]       TAPS_FULL = lfsr_taps(DATA_W);
  localparam logic [DATA_W-1:0] TAPS      = TAPS_FULL[DATA_W-1:0];
  localparam logic [DATA_W-1:0] SEED_W    = SEED[DATA_W-1:0];
  // An all-zero LFSR would lock up, so a zero seed starts from 1.
  localparam logic [DATA_W-1:0] LFSR_SEED = (SEED_W == '0) ? DATA_W'(1) : SEED_W;
  localparam int unsigned       WALK_POS  = 32'(SEED % 64'(DATA_W));
  localparam logic [DATA_W-1:0] WALK_SEED = DATA_W'(1) << WALK_POS;

  logic [DATA_W-1:0] pat_q, pat_d;

  // Next pattern value: reload, step or hold.
  always_comb begin
    pat_d = pat_q;
    if (load) begin
      case (mode)
        TC_MODE_INCR: pat_d = SEED_W;
        TC_MODE_LFSR: pat_d = LFSR_SEED;
        TC_MODE_WALK: pat_d = WALK_SEED;
        default:      pat_d = SEED_W;
      endcase
    end else if (advance) begin
      case (mode)
        TC_MODE_INCR: pat_d = pat_q + DATA_W'(1);
        TC_MODE_LFSR: pat_d = {pat_q[DATA_W-2:0], ^(pat_q & TAPS)};
        TC_MODE_WALK: pat_d = {pat_q[DATA_W-2:0], pat_q[DATA_W-1]};
        default:      pat_d = pat_q;
      endcase
    end
  end

  // Pattern register.
  always_ff @(posedge clk) begin
    if (rst) pat_q <= '0;
    else     pat_q <= pat_d;
  end

  assign data = pat_q;

endmodule

// File: rtl/tc_stream_checker.sv
// Stream testcase engine: drives NUM_VECTORS pattern beats into a DUT over
// valid/ready and checks the in-order response stream against a regenerated
// copy of the pattern, with a no-progress watchdog.
// Ports: clk, rst (sync, active-high), start, mode[1:0],
//   stim_valid/stim_ready/stim_data (stimulus out), resp_valid/resp_data (response in),
//   busy, done, pass, timeout, err_count[ERR_W], vec_count[clog2(NUM_VECTORS+1)].
module tc_stream_checker
  import tc_checker_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NUM_VECTORS = 16,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned ERR_W       = 8,
  parameter logic [63:0] SEED        = 64'd1,
  localparam int unsigned VC_W       = $clog2(NUM_VECTORS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              stim_valid,
  input  logic              stim_ready,
  output logic [DATA_W-1:0] stim_data,
  input  logic              resp_valid,
  input  logic [DATA_W-1:0] resp_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [ERR_W-1:0]  err_count,
  output logic [VC_W-1:0]   vec_count
);

  localparam int unsigned     WD_W    = $clog2(TIMEOUT);
  localparam logic [VC_W-1:0] NV      = VC_W'(NUM_VECTORS);
  localparam logic [VC_W-1:0] NV_M1   = VC_W'(NUM_VECTORS - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 2);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic [1:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [VC_W-1:0]   stim_cnt_q, stim_cnt_d;
  logic [VC_W-1:0]   vec_count_q, vec_count_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              stim_valid_q, stim_valid_d;

  logic              start_c, accept_c, active_c, full_c, expire_c, exp_adv_c;
  logic [1:0]        mode_sel_c;
  logic [DATA_W-1:0] exp_data;

  // Event decode shared by the FSM and the two generators.
  always_comb begin
    start_c    = (state_q == ST_IDLE) && start;
    accept_c   = stim_valid_q && stim_ready;
    active_c   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    full_c     = (vec_count_q == NV);
    // Abort TIMEOUT cycles after the last cycle that carried a response (or start).
    expire_c   = active_c && !resp_valid && (wd_q == WD_LAST);
    exp_adv_c  = active_c && resp_valid && !full_c;
    mode_sel_c = start_c ? mode : mode_q;
  end

  // Next state, counters and registered outputs.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    stim_cnt_d  = stim_cnt_q;
    vec_count_d = vec_count_q;
    err_count_d = err_count_q;
    wd_d        = wd_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          mode_d      = mode;
          stim_cnt_d  = '0;
          vec_count_d = '0;
          err_count_d = '0;
          wd_d        = '0;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
        end
      end
      ST_RUN: begin
        if (accept_c) stim_cnt_d = stim_cnt_q + VC_W'(1);
        if (expire_c) begin
          state_d   = ST_FIN;
          timeout_d = 1'b1;
        end else if (accept_c && (stim_cnt_q == NV_M1)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (expire_c) begin
          state_d   = ST_FIN;
          timeout_d = 1'b1;
        end else if (full_c) begin
          state_d = ST_FIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Response checking and watchdog; beats beyond NUM_VECTORS count as errors only.
    if (active_c) begin
      wd_d = resp_valid ? '0 : wd_q + WD_W'(1);
      if (resp_valid) begin
        if (!full_c) vec_count_d = vec_count_q + VC_W'(1);
        if ((full_c || (resp_data != exp_data)) && (err_count_q != ERR_MAX))
          err_count_d = err_count_q + ERR_W'(1);
      end
    end

    busy_d       = (state_d != ST_IDLE);
    stim_valid_d = (state_d == ST_RUN);
    done_d       = (state_d == ST_FIN);
    if (state_d == ST_FIN) pass_d = (err_count_d == '0) && !timeout_d;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mode_q       <= TC_MODE_INCR;
      stim_cnt_q   <= '0;
      vec_count_q  <= '0;
      err_count_q  <= '0;
      wd_q         <= '0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      stim_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      stim_cnt_q   <= stim_cnt_d;
      vec_count_q  <= vec_count_d;
      err_count_q  <= err_count_d;
      wd_q         <= wd_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      stim_valid_q <= stim_valid_d;
    end
  end

  // Stimulus generator steps on accept; expected generator steps on each in-range response.
  tc_pattern_gen #(.DATA_W(DATA_W), .SEED(SEED)) u_stim_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (start_c),
    .advance (accept_c),
    .mode    (mode_sel_c),
    .data    (stim_data)
  );

  tc_pattern_gen #(.DATA_W(DATA_W), .SEED(SEED)) u_exp_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (start_c),
    .advance (exp_adv_c),
    .mode    (mode_sel_c),
    .data    (exp_data)
  );

  assign stim_valid = stim_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign timeout    = timeout_q;
  assign err_count  = err_count_q;
  assign vec_count  = vec_count_q;

endmodule

// File: tb/tb_tc_stream_checker.sv
// Bench for tc_stream_checker: a configurable DUT model (latency 0..3, beat
// drop, bit flips, injected extra beat) feeds the checker; results are compared
// against a pattern/response model kept here.
module tb_tc_stream_checker;

  localparam int unsigned DW  = 8;
  localparam int unsigned NV  = 16;
  localparam int unsigned TO  = 64;
  localparam int unsigned EW  = 8;
  localparam int unsigned VCW = $clog2(NV + 1);
  localparam int          SEED_I = 1;

  logic          clk = 1'b0;
  logic          rst, start, stim_ready;
  logic [1:0]    mode;
  logic          stim_valid, resp_valid, busy, done, pass, timeout;
  logic [DW-1:0] stim_data, resp_data;
  logic [EW-1:0] err_count;
  logic [VCW-1:0] vec_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tc_stream_checker #(
    .DATA_W(DW), .NUM_VECTORS(NV), .TIMEOUT(TO), .ERR_W(EW), .SEED(64'd1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .stim_valid(stim_valid), .stim_ready(stim_ready), .stim_data(stim_data),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .vec_count(vec_count)
  );

  // ---------------- DUT model ----------------
  int          lat = 0;
  int          drop_idx = -1;
  logic [31:0] flip_mask = '0;
  bit          inj_en = 1'b0;
  int          beat_idx, resp_idx;
  logic        pv [4];
  logic [DW-1:0] pd [4];
  logic        inj_q;
  logic        acc_ok, base_v;
  logic [DW-1:0] acc_d, base_d;

  always_comb begin
    acc_ok = stim_valid && stim_ready && (beat_idx != drop_idx);
    acc_d  = stim_data ^ (((beat_idx < 32) && flip_mask[beat_idx[4:0]]) ? 8'h01 : 8'h00);
    base_v = (lat == 0) ? acc_ok : pv[(lat > 0) ? lat - 1 : 0];
    base_d = (lat == 0) ? acc_d  : pd[(lat > 0) ? lat - 1 : 0];
    resp_valid = base_v || inj_q;
    resp_data  = inj_q ? 8'hA5 : base_d;
  end

  always @(posedge clk) begin
    if (rst || (start && !busy)) begin
      beat_idx <= 0;
      resp_idx <= 0;
      inj_q    <= 1'b0;
      for (int i = 0; i < 4; i++) pv[i] <= 1'b0;
    end else begin
      if (stim_valid && stim_ready) beat_idx <= beat_idx + 1;
      pv[0] <= acc_ok;
      pd[0] <= acc_d;
      for (int i = 1; i < 4; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
      if (base_v) resp_idx <= resp_idx + 1;
      inj_q <= inj_en && base_v && (resp_idx == NV - 1);
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] pat(input logic [1:0] m, input int k);
    int s, fb;
    case (m)
      2'd0: return DW'((SEED_I + k) % 256);
      2'd1: begin
        s = SEED_I;
        for (int i = 0; i < k; i++) begin
          fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
          s  = (s * 2 + fb) % 256;
        end
        return DW'(s);
      end
      2'd2: return DW'(1 << ((SEED_I + k) % DW));
      default: return DW'(SEED_I);
    endcase
  endfunction

  logic [DW-1:0] obs_stim [$];
  logic [DW-1:0] obs_resp [$];
  int done_cyc, done_pulses, to_cyc, last_resp_cyc;
  logic cap_pass, cap_to, cap_busy_after;
  logic [EW-1:0] cap_err;
  logic [VCW-1:0] cap_vec;

  function automatic int model_err(input logic [1:0] m);
    int e = 0;
    for (int i = 0; i < obs_resp.size(); i++)
      if (i >= NV || obs_resp[i] != pat(m, i)) e++;
    return e;
  endfunction

  function automatic int model_vec();
    return (obs_resp.size() > NV) ? NV : obs_resp.size();
  endfunction

  // Drives one run and records what happened; checks are done by the callers.
  task automatic drive_run(input logic [1:0] m, input bit rnd, input int bs_cyc, input int max_cyc);
    obs_stim.delete();
    obs_resp.delete();
    done_cyc = -1; done_pulses = 0; to_cyc = -1; last_resp_cyc = -1;
    @(posedge clk); #1;
    mode = m; start = 1'b1; stim_ready = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == bs_cyc) begin start = 1'b1; mode = 2'd2; end
      stim_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (stim_valid && stim_ready) obs_stim.push_back(stim_data);
      if (resp_valid) begin obs_resp.push_back(resp_data); last_resp_cyc = c; end
      if (timeout && to_cyc < 0) to_cyc = c;
      if (done) begin
        done_pulses++;
        if (done_cyc < 0) begin
          done_cyc = c; cap_pass = pass; cap_to = timeout; cap_err = err_count; cap_vec = vec_count;
        end
      end
      if (done_cyc >= 0 && c == done_cyc + 1) cap_busy_after = busy;
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
    end
    start = 1'b0;
    stim_ready = 1'b1;
  endtask

  task automatic model_reset();
    lat = 0; drop_idx = -1; flip_mask = '0; inj_en = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b1; mode = 2'd1; stim_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1; start = 1'b0;
    #1;
    checks++;
    if ({busy, done, pass, timeout, stim_valid, err_count, vec_count, stim_data} !== '0) begin
      failures++;
      $display("FAIL reset_values busy=%b done=%b pass=%b to=%b sv=%b err=%0d vec=%0d sd=%0h required all zero",
               busy, done, pass, timeout, stim_valid, err_count, vec_count, stim_data);
    end
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL start_with_rst busy=%b required 0", busy);
    end
  endtask

  task automatic test_loopback_incr();
    model_reset();
    drive_run(2'd0, 1'b0, -1, 100);
    checks++;
    if (obs_stim.size() != NV) begin
      failures++; $display("FAIL incr_beats got=%0d required=%0d", obs_stim.size(), NV);
    end
    for (int i = 0; i < obs_stim.size() && i < NV; i++) begin
      checks++;
      if (obs_stim[i] !== DW'(i + 1)) begin
        failures++; $display("FAIL incr_data beat=%0d got=%0d required=%0d", i, obs_stim[i], i + 1);
      end
    end
    checks++;
    if (done_cyc != NV + 2) begin
      failures++; $display("FAIL incr_latency got=%0d required=%0d", done_cyc, NV + 2);
    end
    checks++;
    if ({cap_pass, cap_to, cap_err, cap_vec} !== {1'b1, 1'b0, EW'(0), VCW'(NV)}) begin
      failures++;
      $display("FAIL incr_status pass=%b to=%b err=%0d vec=%0d required 1 0 0 %0d",
               cap_pass, cap_to, cap_err, cap_vec, NV);
    end
    checks++;
    if (done_pulses != 1 || cap_busy_after !== 1'b0) begin
      failures++; $display("FAIL incr_done_pulse pulses=%0d busy_after=%b required 1 0", done_pulses, cap_busy_after);
    end
  endtask

  task automatic test_lfsr_stall();
    model_reset(); lat = 3;
    drive_run(2'd1, 1'b1, -1, 300);
    checks++;
    if (obs_stim.size() != NV) begin
      failures++; $display("FAIL lfsr_beats got=%0d required=%0d", obs_stim.size(), NV);
    end
    for (int i = 0; i < obs_stim.size() && i < NV; i++) begin
      checks++;
      if (obs_stim[i] !== pat(2'd1, i)) begin
        failures++; $display("FAIL lfsr_data beat=%0d got=%0h required=%0h", i, obs_stim[i], pat(2'd1, i));
      end
    end
    checks++;
    if ({cap_pass, cap_to, cap_err, cap_vec} !== {1'b1, 1'b0, EW'(0), VCW'(NV)} || done_cyc < 0) begin
      failures++;
      $display("FAIL lfsr_status pass=%b to=%b err=%0d vec=%0d done_cyc=%0d required 1 0 0 %0d",
               cap_pass, cap_to, cap_err, cap_vec, done_cyc, NV);
    end
  endtask

  task automatic test_bitflip();
    model_reset(); flip_mask[3] = 1'b1; flip_mask[7] = 1'b1;
    drive_run(2'd0, 1'b0, -1, 100);
    checks++;
    if (cap_err !== EW'(2) || cap_err !== EW'(model_err(2'd0))) begin
      failures++; $display("FAIL flip_err got=%0d required=2 model=%0d", cap_err, model_err(2'd0));
    end
    checks++;
    if ({cap_pass, cap_to, cap_vec} !== {1'b0, 1'b0, VCW'(NV)}) begin
      failures++; $display("FAIL flip_status pass=%b to=%b vec=%0d required 0 0 %0d", cap_pass, cap_to, cap_vec, NV);
    end
  endtask

  task automatic test_drop_timeout();
    model_reset(); drop_idx = 10;
    drive_run(2'd0, 1'b0, -1, 250);
    checks++;
    if (cap_to !== 1'b1 || to_cyc != last_resp_cyc + int'(TO)) begin
      failures++;
      $display("FAIL drop_timeout to=%b to_cyc=%0d required 1 at %0d", cap_to, to_cyc, last_resp_cyc + int'(TO));
    end
    checks++;
    if (cap_vec !== VCW'(NV - 1) || cap_pass !== 1'b0) begin
      failures++; $display("FAIL drop_status vec=%0d pass=%b required %0d 0", cap_vec, cap_pass, NV - 1);
    end
    checks++;
    if (cap_err !== EW'(model_err(2'd0))) begin
      failures++; $display("FAIL drop_err got=%0d required=%0d", cap_err, model_err(2'd0));
    end
    checks++;
    if (done_pulses != 1) begin
      failures++; $display("FAIL drop_done_pulse got=%0d required=1", done_pulses);
    end
  endtask

  task automatic test_extra_and_busy_start();
    model_reset(); lat = 3; inj_en = 1'b1;
    drive_run(2'd0, 1'b0, 6, 100);
    checks++;
    if (cap_err !== EW'(1) || cap_err !== EW'(model_err(2'd0))) begin
      failures++; $display("FAIL extra_err got=%0d required=1 model=%0d", cap_err, model_err(2'd0));
    end
    checks++;
    if ({cap_pass, cap_to, cap_vec} !== {1'b0, 1'b0, VCW'(model_vec())}) begin
      failures++; $display("FAIL extra_status pass=%b to=%b vec=%0d required 0 0 %0d", cap_pass, cap_to, cap_vec, model_vec());
    end
    for (int i = 0; i < obs_stim.size(); i++) begin
      checks++;
      if (obs_stim[i] !== pat(2'd0, i)) begin
        failures++; $display("FAIL busy_start_data beat=%0d got=%0h required=%0h", i, obs_stim[i], pat(2'd0, i));
      end
    end
    checks++;
    if (done_pulses != 1) begin
      failures++; $display("FAIL extra_done_pulse got=%0d required=1", done_pulses);
    end
  endtask

  task automatic test_rst_mid_run();
    int acc = 0;
    int seen_done = 0;
    model_reset();
    @(posedge clk); #1;
    mode = 2'd0; start = 1'b1; stim_ready = 1'b1;
    for (int c = 0; c < 60 && acc < 5; c++) begin
      @(posedge clk); #1; start = 1'b0; #1;
      if (stim_valid && stim_ready) acc++;
    end
    checks++;
    if (acc != 5) begin
      failures++; $display("FAIL rst_mid_reach accepted=%0d required=5", acc);
    end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; #1;
    checks++;
    if ({busy, stim_valid, done, err_count, vec_count} !== '0) begin
      failures++;
      $display("FAIL rst_mid_values busy=%b sv=%b done=%b err=%0d vec=%0d required all zero",
               busy, stim_valid, done, err_count, vec_count);
    end
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #2;
      if (done) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      failures++; $display("FAIL rst_mid_no_done got=%0d required=0", seen_done);
    end
    drive_run(2'd0, 1'b0, -1, 100);
    checks++;
    if ({cap_pass, cap_err, cap_vec} !== {1'b1, EW'(0), VCW'(NV)}) begin
      failures++; $display("FAIL rst_rerun pass=%b err=%0d vec=%0d required 1 0 %0d", cap_pass, cap_err, cap_vec, NV);
    end
  endtask

  task automatic test_all_modes();
    for (int m = 0; m < 4; m++) begin
      model_reset(); lat = $urandom_range(0, 3);
      drive_run(2'(m), 1'b1, -1, 300);
      checks++;
      if (obs_stim.size() != NV) begin
        failures++; $display("FAIL mode%0d_beats got=%0d required=%0d", m, obs_stim.size(), NV);
      end
      for (int i = 0; i < obs_stim.size() && i < NV; i++) begin
        checks++;
        if (obs_stim[i] !== pat(2'(m), i)) begin
          failures++; $display("FAIL mode%0d_data beat=%0d got=%0h required=%0h", m, i, obs_stim[i], pat(2'(m), i));
        end
      end
      checks++;
      if ({cap_pass, cap_to, cap_err, cap_vec} !== {1'b1, 1'b0, EW'(0), VCW'(NV)}) begin
        failures++;
        $display("FAIL mode%0d_status lat=%0d pass=%b to=%b err=%0d vec=%0d required 1 0 0 %0d",
                 m, lat, cap_pass, cap_to, cap_err, cap_vec, NV);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; stim_ready = 1'b1;
    test_reset();
    test_loopback_incr();
    test_lfsr_stall();
    test_bitflip();
    test_drop_timeout();
    test_extra_and_busy_start();
    test_rst_mid_run();
    test_all_modes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_time_limit reached checks=%0d", checks);
    $fatal(1);
  end

endmodule
